bus_arbiter_rr4: RTL

- Round-robin arbiter that shares one N-bit datapath between four requesters.
- Registers a one-hot grant and a 2-bit select, then drives the shared output through a 4:1 N-bit mux.
- Sits in front of shared buses, for example register-file write-back or memory-port sharing between pipeline units.
- Includes a hold limit so no requester can monopolise the bus.

---
 rtl/bus_arb_pkg.sv | 36 +++
 rtl/mux4to1_nbit_arb.sv | 26 ++
 rtl/bus_arbiter_rr4.sv | 117 +++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and the round-robin pick function for the 4-way bus arbiter.
// Latency: none (pure types and combinational helper).
// Backpressure: none; requests are level-sensitive and never latched.
package bus_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan last+1, last+2, last+3, last (mod 4); the first asserted line wins.
    // The loop walks from lowest to highest priority so the last hit is the winner.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   last);
        pick_t            p;
        logic [SEL_W-1:0] cand;
        p = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = last + SEL_W'(k);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux4to1_nbit_arb.sv
// Shared-datapath 4:1 N-bit mux steered by the arbiter's registered select.
// Latency: combinational, input changes appear on f in the same cycle.
// Backpressure: none; consumers qualify f with the arbiter's valid.
module mux4to1_nbit_arb #(
    parameter int N = 64
) (
    input  logic [1:0]   sel_i,
    input  logic [N-1:0] d0_i,
    input  logic [N-1:0] d1_i,
    input  logic [N-1:0] d2_i,
    input  logic [N-1:0] d3_i,
    output logic [N-1:0] f_o
);

    // Select one requester's data word.
    always_comb begin
        f_o = d0_i;
        case (sel_i)
            2'd0:    f_o = d0_i;
            2'd1:    f_o = d1_i;
            2'd2:    f_o = d2_i;
            default: f_o = d3_i;
        endcase
    end

endmodule

// File: rtl/bus_arbiter_rr4.sv
// Round-robin arbiter with per-tenure hold limit sharing one N-bit bus among 4 requesters.
// Latency: 1 cycle from request to registered grant; F follows D[sel] combinationally.
// Backpressure: level-sensitive requests, a dropped request is forgotten; owner rotates after MAX_HOLD cycles.
module bus_arbiter_rr4
    import bus_arb_pkg::*;
#(
    parameter int N        = 64,
    parameter int MAX_HOLD = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [N-1:0] D0,
    input  logic [N-1:0] D1,
    input  logic [N-1:0] D2,
    input  logic [N-1:0] D3,
    output logic [3:0]   grant,
    output logic [1:0]   sel,
    output logic         busy,
    output logic [N-1:0] F,
    output logic         valid
);

    // Hold counter compares against MAX_HOLD-1; zero disables forced rotation.
    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic [SEL_W-1:0] last_q,  last_d;
    logic [7:0]       hold_q,  hold_d;

    pick_t pick_idle;
    pick_t pick_own;

    // Next-state: new tenure from IDLE, hand-off on release, forced rotation, or hold.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        hold_d    = hold_q;
        pick_idle = rr_pick(req, last_q);
        pick_own  = rr_pick(req, sel_q);

        case (state_q)
            IDLE: begin
                if (pick_idle.found) begin
                    state_d = OWN;
                    grant_d = 4'b0001 << pick_idle.idx;
                    sel_d   = pick_idle.idx;
                    last_d  = pick_idle.idx;
                    hold_d  = 8'd0;
                end
            end
            OWN: begin
                if (!req[sel_q]) begin
                    // Owner released: hand straight to the next requester, no idle bubble.
                    hold_d = 8'd0;
                    if (pick_own.found) begin
                        grant_d = 4'b0001 << pick_own.idx;
                        sel_d   = pick_own.idx;
                        last_d  = pick_own.idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                    end
                end else if (HOLD_EN && hold_q == HOLD_LAST) begin
                    // Tenure exhausted; the owner is still requesting so a winner always exists.
                    grant_d = 4'b0001 << pick_own.idx;
                    sel_d   = pick_own.idx;
                    last_d  = pick_own.idx;
                    hold_d  = 8'd0;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // State registers; reset drops the grant immediately and restarts priority at requester 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = |grant_q;
    assign valid = |grant_q;

    mux4to1_nbit_arb #(.N(N)) u_mux (
        .sel_i (sel_q),
        .d0_i  (D0),
        .d1_i  (D1),
        .d2_i  (D2),
        .d3_i  (D3),
        .f_o   (F)
    );

endmodule
